fetch_redirect_unit: RTL and testbench



---
 rtl/fetch_redirect_unit_pkg.sv | 14 +
 rtl/fetch_redirect_unit_if.sv | 55 +++++
 rtl/fetch_redirect_unit_branch_target_calc.sv | 41 ++++
 rtl/fetch_redirect_unit.sv | 122 ++++++++++++
 tb/tb_fetch_redirect_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect unit: FSM state encoding and PC constants.
package fetch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bus bundle: imem req/ready, decode valid/ready, branch resolution and status.
// Statistics counters are present only with FETCH_REDIRECT_STATS_EN defined.
interface fetch_redirect_unit_if
`ifdef FETCH_REDIRECT_STATS_EN
  #(parameter int STATS_W = 16)
`endif
  ;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        br_valid;
  logic        beq_control;
  logic        bne_control;
  logic        bltz_control;
  logic        jump_control;
  logic        jump_reg;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] br_offset;
  logic [25:0] jump_target;
  logic [31:0] br_pc;
  logic        flush;
  logic [31:0] pc;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [STATS_W-1:0] stat_fetched;
  logic [STATS_W-1:0] stat_taken;
  logic [STATS_W-1:0] stat_flushed;
`endif

  modport master (
`ifdef FETCH_REDIRECT_STATS_EN
    output stat_fetched, stat_taken, stat_flushed,
`endif
    output imem_req, imem_addr, if_valid, if_instr, if_pc, flush, pc,
    input  imem_ready, imem_rdata, if_ready, br_valid, beq_control, bne_control,
    input  bltz_control, jump_control, jump_reg, rs_val, rt_val, br_offset,
    input  jump_target, br_pc
  );

  modport slave (
`ifdef FETCH_REDIRECT_STATS_EN
    input  stat_fetched, stat_taken, stat_flushed,
`endif
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, flush, pc,
    output imem_ready, imem_rdata, if_ready, br_valid, beq_control, bne_control,
    output bltz_control, jump_control, jump_reg, rs_val, rt_val, br_offset,
    output jump_target, br_pc
  );

endinterface

// File: rtl/fetch_redirect_unit_branch_target_calc.sv
// Combinational taken/target evaluation; priority jump > beq > bne > bltz.
module branch_target_calc
  import fetch_redirect_unit_pkg::*;
(
  input  logic        i_br_valid,
  input  logic        i_beq,
  input  logic        i_bne,
  input  logic        i_bltz,
  input  logic        i_jump,
  input  logic        i_jump_reg,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic [15:0] i_br_offset,
  input  logic [25:0] i_jump_target,
  input  logic [31:0] i_br_pc,
  output logic        o_taken,
  output logic [31:0] o_target
);

  logic [31:0] w_seq_pc;
  logic [31:0] w_br_target;

  assign w_seq_pc    = i_br_pc + PC_INC;
  assign w_br_target = w_seq_pc + {{14{i_br_offset[15]}}, i_br_offset, 2'b00};

  always_comb begin
    o_taken  = 1'b0;
    o_target = w_br_target;
    if (i_jump) begin
      o_taken  = i_br_valid;
      o_target = i_jump_reg ? i_rs_val : {w_seq_pc[31:28], i_jump_target, 2'b00};
    end else if (i_beq) begin
      o_taken = i_br_valid && (i_rs_val == i_rt_val);
    end else if (i_bne) begin
      o_taken = i_br_valid && (i_rs_val != i_rt_val);
    end else if (i_bltz) begin
      o_taken = i_br_valid && i_rs_val[31];
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC owner: fetches one word at a time (req held until ready, 1-cycle to if_valid), holds it for decode
// until if_ready, and redirects/flushes on taken branches. FETCH_REDIRECT_STATS_EN adds saturating counters.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef FETCH_REDIRECT_STATS_EN
  , parameter int STATS_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_redirect_unit_if.master bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_flush;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_capture;

  branch_target_calc u_calc (
    .i_br_valid    (bus.br_valid),
    .i_beq         (bus.beq_control),
    .i_bne         (bus.bne_control),
    .i_bltz        (bus.bltz_control),
    .i_jump        (bus.jump_control),
    .i_jump_reg    (bus.jump_reg),
    .i_rs_val      (bus.rs_val),
    .i_rt_val      (bus.rt_val),
    .i_br_offset   (bus.br_offset),
    .i_jump_target (bus.jump_target),
    .i_br_pc       (bus.br_pc),
    .o_taken       (w_taken),
    .o_target      (w_target)
  );

  assign w_capture = (r_state == FETCH) && bus.imem_ready && !w_taken;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  w_next_state = FETCH;
      FETCH: begin
        if (bus.imem_ready) w_next_state = w_taken ? FETCH : HOLD;
        else if (w_taken)   w_next_state = DRAIN;
      end
      HOLD:  if (w_taken || bus.if_ready) w_next_state = FETCH;
      DRAIN: if (bus.imem_ready) w_next_state = FETCH;
      default: w_next_state = IDLE;
    endcase
  end

  // DRAIN keeps presenting the abandoned address until memory takes it.
  always_comb begin
    bus.imem_req  = (r_state == FETCH) || (r_state == DRAIN);
    bus.imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;
    bus.if_valid  = (r_state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
      r_flush      <= 1'b0;
    end else begin
      r_flush <= w_taken;
      if (w_capture) begin
        r_if_instr <= bus.imem_rdata;
        r_if_pc    <= r_pc;
      end
      if ((r_state == FETCH) && !bus.imem_ready && w_taken) r_drain_addr <= r_pc;
      if (w_taken)        r_pc <= w_target;
      else if (w_capture) r_pc <= r_pc + PC_INC;
    end
  end

  assign bus.if_instr = r_if_instr;
  assign bus.if_pc    = r_if_pc;
  assign bus.flush    = r_flush;
  assign bus.pc       = r_pc;

`ifdef FETCH_REDIRECT_STATS_EN
  logic [STATS_W-1:0] r_stat_fetched;
  logic [STATS_W-1:0] r_stat_taken;
  logic [STATS_W-1:0] r_stat_flushed;
  logic               w_accept;
  logic               w_drop;

  assign w_accept = (r_state == HOLD) && bus.if_ready && !w_taken;
  assign w_drop   = ((r_state == HOLD) && w_taken) || ((r_state == DRAIN) && bus.imem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_taken   <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_accept && (r_stat_fetched != '1)) r_stat_fetched <= r_stat_fetched + STATS_W'(1);
      if (w_taken  && (r_stat_taken   != '1)) r_stat_taken   <= r_stat_taken + STATS_W'(1);
      if (w_drop   && (r_stat_flushed != '1)) r_stat_flushed <= r_stat_flushed + STATS_W'(1);
    end
  end

  assign bus.stat_fetched = r_stat_fetched;
  assign bus.stat_taken   = r_stat_taken;
  assign bus.stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench for fetch_redirect_unit against a transaction-level fetch/redirect model.
module tb_fetch_redirect_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef FETCH_REDIRECT_STATS_EN
  fetch_redirect_unit_if #(.STATS_W(16)) bus ();
  fetch_redirect_unit #(.STATS_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  fetch_redirect_unit_if bus ();
  fetch_redirect_unit dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: what the fetch side has promised at the architectural level.
  bit          m_boot, m_busy, m_drop, m_held, m_flush;
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  int          m_fetched, m_taken, m_flushed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit          tk;
    logic [31:0] tg;
    logic [31:0] seq;
    int          off;
    if (reset) begin
      m_boot = 1; m_busy = 0; m_drop = 0; m_held = 0; m_flush = 0;
      m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      m_fetched = 0; m_taken = 0; m_flushed = 0;
      return;
    end
    seq = bus.br_pc + 32'd4;
    off = $signed(bus.br_offset);
    tg  = seq + 32'(off * 4);
    if (bus.jump_control) begin
      tk = 1;
      tg = bus.jump_reg ? bus.rs_val : {seq[31:28], bus.jump_target, 2'b00};
    end else if (bus.beq_control) tk = (bus.rs_val == bus.rt_val);
    else if (bus.bne_control)     tk = (bus.rs_val != bus.rt_val);
    else if (bus.bltz_control)    tk = ($signed(bus.rs_val) < 0);
    else                          tk = 0;
    tk = tk && bus.br_valid;
    m_flush = tk;
    if (tk) m_taken++;
    if (m_boot) begin
      m_boot = 0;
      if (tk) m_pc = tg;
      m_busy = 1; m_addr = m_pc;
    end else if (m_held) begin
      if (tk) begin
        m_flushed++; m_pc = tg; m_held = 0; m_busy = 1; m_addr = m_pc;
      end else if (bus.if_ready) begin
        m_fetched++; m_held = 0; m_busy = 1; m_addr = m_pc;
      end
    end else if (m_drop) begin
      if (tk) m_pc = tg;
      if (bus.imem_ready) begin
        m_drop = 0; m_flushed++; m_addr = m_pc;
      end
    end else if (m_busy) begin
      if (bus.imem_ready) begin
        if (tk) begin
          m_pc = tg; m_addr = m_pc;
        end else begin
          m_busy = 0; m_held = 1; m_instr = bus.imem_rdata; m_ipc = m_addr; m_pc = m_addr + 32'd4;
        end
      end else if (tk) begin
        m_drop = 1; m_pc = tg;
      end
    end
  endtask

  task automatic compare();
    chk("pc", bus.pc, m_pc);
    chk("imem_req", 32'(bus.imem_req), 32'(m_busy));
    if (m_busy) chk("imem_addr", bus.imem_addr, m_addr);
    chk("if_valid", 32'(bus.if_valid), 32'(m_held));
    if (m_held) begin
      chk("if_instr", bus.if_instr, m_instr);
      chk("if_pc", bus.if_pc, m_ipc);
    end
    chk("flush", 32'(bus.flush), 32'(m_flush));
`ifdef FETCH_REDIRECT_STATS_EN
    chk("stat_fetched", 32'(bus.stat_fetched), 32'(m_fetched));
    chk("stat_taken", 32'(bus.stat_taken), 32'(m_taken));
    chk("stat_flushed", 32'(bus.stat_flushed), 32'(m_flushed));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic clear_br();
    bus.br_valid = 0; bus.beq_control = 0; bus.bne_control = 0;
    bus.bltz_control = 0; bus.jump_control = 0; bus.jump_reg = 0;
  endtask

  task automatic set_br(input logic [4:0] ctl, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] off, input logic [25:0] jt, input logic [31:0] bpc);
    {bus.jump_control, bus.jump_reg, bus.beq_control, bus.bne_control, bus.bltz_control} = ctl;
    bus.br_valid = 1; bus.rs_val = rs; bus.rt_val = rt;
    bus.br_offset = off; bus.jump_target = jt; bus.br_pc = bpc;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 8 && !bus.imem_req; i++) cycle();
    chk(tag, 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_a;
    int          sel;
    reset = 1;
    clear_br();
    bus.imem_ready = 0; bus.imem_rdata = 0; bus.if_ready = 0;
    bus.rs_val = 0; bus.rt_val = 0; bus.br_offset = 0; bus.jump_target = 0; bus.br_pc = 0;
    cycle(); cycle();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    reset = 0;

    // Stream at full rate.
    bus.imem_ready = 1; bus.if_ready = 1; exp_a = 32'h0;
    for (int i = 0; i < 8; i++) begin
      bus.imem_rdata = $urandom;
      cycle();
      if (bus.imem_req) begin
        chk("stream_addr", bus.imem_addr, exp_a);
        exp_a += 32'd4;
      end else chk("stream_if_pc", bus.if_pc, exp_a - 32'd4);
    end

    // Backpressure in HOLD.
    bus.if_ready = 0;
    for (int i = 0; i < 4 && !bus.if_valid; i++) cycle();
    chk("bp_reach_hold", 32'(bus.if_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_req", 32'(bus.imem_req), 32'd0);
      chk("bp_pc", bus.pc, m_ipc + 32'd4);
    end
    bus.if_ready = 1;

    // beq taken with negative offset.
    set_br(5'b00100, 32'd7, 32'd7, 16'hFFFE, 26'h0, 32'h100);
    cycle(); clear_br();
    chk("beq_flush", 32'(bus.flush), 32'd1);
    chk("beq_addr", bus.imem_addr, 32'h0FC);
    cycle();
    chk("beq_flush_pulse", 32'(bus.flush), 32'd0);

    // Redirect while the request is still outstanding.
    bus.imem_ready = 0;
    wait_req("drain_wait_req");
    exp_a = bus.imem_addr;
    set_br(5'b10000, 32'h0, 32'h0, 16'h0, 26'h123, 32'h100);
    cycle(); clear_br();
    for (int i = 0; i < 3; i++) begin
      bus.imem_rdata = $urandom;
      cycle();
      chk("drain_addr_held", bus.imem_addr, exp_a);
      chk("drain_no_valid", 32'(bus.if_valid), 32'd0);
    end
    bus.imem_ready = 1;
    cycle();
    chk("drain_no_valid_after", 32'(bus.if_valid), 32'd0);
    chk("drain_new_addr", bus.imem_addr, 32'h48C);

    // jr wins over bne; bltz sign test.
    set_br(5'b11010, 32'h2000, 32'h1, 16'h10, 26'h0, 32'h100);
    cycle(); clear_br();
    chk("jr_addr", bus.imem_addr, 32'h2000);
    set_br(5'b00001, 32'h8000_0000, 32'h0, 16'h3, 26'h0, 32'h200);
    cycle(); clear_br();
    chk("bltz_taken", 32'(bus.flush), 32'd1);
    chk("bltz_addr", bus.imem_addr, 32'h210);
    set_br(5'b00001, 32'h7FFF_FFFF, 32'h0, 16'h3, 26'h0, 32'h300);
    cycle(); clear_br();
    chk("bltz_not_taken", 32'(bus.flush), 32'd0);

    // Reset in the middle of a fetch.
    bus.imem_ready = 0;
    wait_req("rst_wait_req");
    reset = 1;
    cycle();
    chk("midrst_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_pc", bus.pc, 32'h0);
    chk("midrst_valid", 32'(bus.if_valid), 32'd0);
`ifdef FETCH_REDIRECT_STATS_EN
    chk("midrst_stats", 32'(bus.stat_fetched) | 32'(bus.stat_taken) | 32'(bus.stat_flushed), 32'd0);
`endif
    reset = 0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.imem_ready = ($urandom_range(0, 9) < 6);
      bus.if_ready   = ($urandom_range(0, 9) < 6);
      bus.imem_rdata = $urandom;
      clear_br();
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 5);
        set_br(5'(1 << $urandom_range(0, 4)) | ((sel == 5) ? 5'(($urandom & 5'h1F)) : 5'h0),
               $urandom, $urandom, 16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC);
        if ($urandom_range(0, 1) == 1) bus.rt_val = bus.rs_val;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
